// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - MDU_* op encodings (R-type FUNC[1:0])
//   - mdu_state_e : control FSM states
//   - MDU_ITER    : iterations per operation (one result bit per cycle)
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Per-cycle datapath of the multiply/divide unit. It works on unsigned
// magnitudes only; sign handling lives in the top.
//   clk      : clock
//   load_i   : capture operands, clear remainder and iteration counter
//   step_i   : perform one shift-add (multiply) or restore-subtract (divide)
//   is_div_i : operation class, sampled with load_i
//   a_i      : multiplicand / dividend magnitude
//   b_i      : multiplier / divisor magnitude
//   last_o   : the current step is the final iteration
//   prod_o   : 2*WIDTH-bit product
//   quo_o    : quotient
//   rem_o    : remainder
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quo_o,
  output logic [WIDTH-1:0]   rem_o
);

  localparam int CNT_W = $clog2(MDU_ITER);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // WIDTH+1-bit partial remainder after bringing down the next dividend bit.
    rem_sh  = {rem_q, acc_q[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, opnd_q};

    if (load_i) begin
      is_div_d = is_div_i;
      opnd_d   = is_div_i ? b_i : a_i;
      acc_d    = {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
      rem_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        // Partial remainder stays below the divisor, so WIDTH bits suffice.
        rem_d              = rem_ge ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0];
        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], rem_ge};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    rem_q    <= rem_d;
    cnt_q    <= cnt_d;
    is_div_q <= is_div_d;
  end

  assign last_o = (cnt_q == CNT_W'(MDU_ITER - 1));
  assign prod_o = acc_q;
  assign quo_o  = acc_q[WIDTH-1:0];
  assign rem_o  = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// An accepted start takes 34 cycles to done; HI/LO hold stale values
// until the FIX cycle writes the result.
//   clk, reset       : clock, synchronous active-high reset
//   start, op        : launch request and FUNC[1:0] operation select
//   rs_data, rt_data : multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we     : MTHI/MTLO strobes writing wdata (IDLE only)
//   busy             : operation in flight
//   done             : one-cycle pulse after HI/LO receive a result
//   div_by_zero      : pulses with done for a divide by zero
//   hi, lo           : HI/LO registers
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x,
                                           input logic is_signed);
    // The magnitude of the most negative value wraps to itself, which is
    // exactly the unsigned magnitude needed downstream.
    return (is_signed && x[WIDTH-1]) ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? WIDTH'(-x) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (2*WIDTH)'(-x) : x;
  endfunction

  mdu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, dbz_q;

  logic               is_div_q, neg_a_q, neg_b_q, b_zero_q;
  logic [WIDTH-1:0]   rs_q;

  logic               accept, signed_op, last;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  assign accept    = (state_q == IDLE) && start;
  assign signed_op = ~op[0];

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .load_i   (accept),
    .step_i   (state_q == RUN),
    .is_div_i (op[1]),
    .a_i      (mag(rs_data, signed_op)),
    .b_i      (mag(rt_data, signed_op)),
    .last_o   (last),
    .prod_o   (prod),
    .quo_o    (quo),
    .rem_o    (rem)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign prod_fix = neg_2w(prod, neg_a_q ^ neg_b_q);

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == FIX) begin
      if (!is_div_q) begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end else if (b_zero_q) begin
        hi_d = rs_q;
        lo_d = '1;
      end else begin
        // Remainder follows the dividend sign: truncation toward zero.
        hi_d = neg_w(rem, neg_a_q);
        lo_d = neg_w(quo, neg_a_q ^ neg_b_q);
      end
    end else if ((state_q == IDLE) && !start) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= (state_q == FIX);
      dbz_q   <= (state_q == FIX) && is_div_q && b_zero_q;
    end
  end

  // Operand attributes captured at the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_q <= op[1];
      neg_a_q  <= signed_op && rs_data[WIDTH-1];
      neg_b_q  <= signed_op && rt_data[WIDTH-1];
      b_zero_q <= (rt_data == '0);
      rs_q     <= rs_data;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
